// File: rtl/mem_access_unit.sv
// Memory access unit: sequences CPU loads/stores onto a single-cycle RAM/MMIO bus with sub-word merge.
// Define MAU_MISALIGN_CHECK_EN to abort misaligned halfword/word accesses with rsp_misalign.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misalign,
    output logic [31:0] bus_adr,
    output logic [31:0] bus_wdin,
    output logic        bus_we,
    input  logic [31:0] bus_rd,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready (ready only in IDLE);
    // rsp_valid is a single-cycle pulse that cannot be stalled.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    logic [1:0]  a_lane;
    logic [1:0]  a_size;
    logic        a_uns;
    logic        a_we;
    logic        a_mmio;
    logic [15:0] a_wdata;

    logic        req_mmio;
    logic        req_sub;
    logic        req_mis;
    logic [31:0] req_bus_adr;

    always_comb begin
        req_mmio    = (req_addr[31:12] == 20'hFFFFF);
        req_sub     = ~req_size[1];
        req_bus_adr = req_mmio ? req_addr : {req_addr[31:2], 2'b00};
`ifdef MAU_MISALIGN_CHECK_EN
        req_mis     = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
        req_mis     = 1'b0;
`endif
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] st_data;

    // Load extraction and sub-word merge both work on the word currently on bus_rd.
    always_comb begin
        ld_byte = bus_rd[{a_lane, 3'b000} +: 8];
        ld_half = bus_rd[{a_lane[1], 4'b0000} +: 16];
        if (a_mmio || a_size[1])
            ld_data = bus_rd;
        else if (a_size[0])
            ld_data = {{16{ld_half[15] & ~a_uns}}, ld_half};
        else
            ld_data = {{24{ld_byte[7] & ~a_uns}}, ld_byte};
        st_data = bus_rd;
        if (a_size[0])
            st_data[{a_lane[1], 4'b0000} +: 16] = a_wdata;
        else
            st_data[{a_lane, 3'b000} +: 8] = a_wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'h0;
            rsp_misalign <= 1'b0;
            bus_adr      <= 32'h0;
            bus_wdin     <= 32'h0;
            bus_we       <= 1'b0;
            a_lane       <= 2'b00;
            a_size       <= 2'b00;
            a_uns        <= 1'b0;
            a_we         <= 1'b0;
            a_mmio       <= 1'b0;
            a_wdata      <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_lane    <= req_addr[1:0];
                        a_size    <= req_size;
                        a_uns     <= req_unsigned;
                        a_we      <= req_we;
                        a_mmio    <= req_mmio;
                        a_wdata   <= req_wdata[15:0];
                        req_ready <= 1'b0;
                        if (req_mis) begin
                            state        <= RESP;
                            rsp_valid    <= 1'b1;
                            rsp_misalign <= 1'b1;
                            rsp_rdata    <= 32'h0;
                        end else if (!req_we || (req_sub && !req_mmio)) begin
                            // Loads and RAM sub-word stores need the current word first.
                            state   <= READ;
                            bus_adr <= req_bus_adr;
                        end else begin
                            state    <= WRITE;
                            bus_adr  <= req_bus_adr;
                            bus_wdin <= req_wdata;
                            bus_we   <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (a_we) begin
                        state    <= WRITE;
                        bus_wdin <= st_data;
                        bus_we   <= 1'b1;
                    end else begin
                        state        <= RESP;
                        rsp_valid    <= 1'b1;
                        rsp_misalign <= 1'b0;
                        rsp_rdata    <= ld_data;
                        bus_adr      <= 32'h0;
                    end
                end
                WRITE: begin
                    state        <= RESP;
                    bus_we       <= 1'b0;
                    bus_adr      <= 32'h0;
                    bus_wdin     <= 32'h0;
                    rsp_valid    <= 1'b1;
                    rsp_misalign <= 1'b0;
                end
                RESP: begin
                    state        <= IDLE;
                    rsp_valid    <= 1'b0;
                    rsp_misalign <= 1'b0;
                    req_ready    <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: req_valid  input  1  CPU access request.
REQ-004 SHALL have port: req_ready  output  1  unit idle, request accepted when req_valid && req_ready.
REQ-005 SHALL have port: req_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port: req_size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-007 SHALL have port: req_unsigned  input  1  zero-extend sub-word loads (lbu/lhu).
REQ-008 SHALL have port: req_addr  input  32  byte address.
REQ-009 SHALL have port: req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port: rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port: rsp_rdata  output  32  load result, held until next rsp_valid.
REQ-012 SHALL have port: rsp_misalign  output  1  qualifies rsp_valid: access aborted as misaligned.
REQ-013 SHALL have ports: bus_adr  output  32; bus_wdin  output  32; bus_we  output  1; bus_rd  input  32 -- data-memory/MMIO bus (combinational read, write on clock).

Function
REQ-014 SHALL implement states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL register addr, size, unsigned, we, wdata on acceptance; later req_* changes have no effect until IDLE.
REQ-016 RAM region (req_addr[31:12] != 20'hFFFFF): bus_adr = {addr[31:2],2'b00}.
REQ-017 MMIO region (req_addr[31:12] == 20'hFFFFF): bus_adr = full addr unmodified; bus_wdin = wdata unshifted; rsp_rdata = bus_rd unshifted; no read-modify-write.
REQ-018 Load: IDLE -> READ (capture bus_rd at end of cycle) -> RESP; accept in cycle N, rsp_valid in N+2.
REQ-019 Load extraction (RAM): byte lane addr[1:0], half lane addr[1]; sign-extend unless req_unsigned; word unchanged.
REQ-020 Word store or any MMIO store: IDLE -> WRITE (bus_we = 1 exactly one cycle) -> RESP.
REQ-021 Sub-word RAM store: IDLE -> READ -> WRITE with old word merged with new byte/half at its lane -> RESP; rsp_valid at N+3.
REQ-022 bus_we SHALL be 1 only in WRITE; bus_adr/bus_wdin stable through READ and WRITE.
REQ-023 RESP -> IDLE unconditionally; rsp_valid = 1 only in RESP; no response backpressure.
REQ-024 Outside READ/WRITE, bus_adr = 0, bus_wdin = 0, bus_we = 0.
REQ-025 Store response: rsp_rdata unchanged, rsp_misalign = 0.

Reset
REQ-026 rst_n low SHALL force IDLE, rsp_valid = 0, rsp_misalign = 0, rsp_rdata = 0, bus_we = 0 immediately, including mid-operation; aborted access produces no response and no later write.
REQ-027 First request SHALL be accepted on the first rising clk edge after rst_n deasserts.

Configuration
REQ-028 Macro MAU_MISALIGN_CHECK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL go IDLE -> RESP with no bus access, rsp_misalign = 1, rsp_rdata = 0, rsp_valid at N+1.
REQ-029 Macro undefined: offending low address bits SHALL be ignored (half uses addr[1], word uses aligned word), rsp_misalign tied 0.

Verification
REQ-030 RAM 0x100 = 0x8899AABB; lb 0x101 -> rsp_rdata 0xFFFFFFAA at N+2; lbu 0x101 -> 0x000000AA.
REQ-031 RAM 0x100 = 0x8899AABB; sh 0x102 data 0x00001234 -> one bus_we pulse, word 0x1234AABB, rsp_valid at N+3.
REQ-032 sw 0xFFFFF060 data 0x0000F00F -> bus_adr 0xFFFFF060, bus_wdin 0x0000F00F, no READ cycle; lw 0xFFFFF070 with bus_rd 0x00005A5A -> rsp_rdata 0x00005A5A.
REQ-033 With MAU_MISALIGN_CHECK_EN: lw 0x102 -> rsp_misalign 1, rsp_rdata 0 at N+1, bus_we never 1.
REQ-034 sb 0x200 accepted, rst_n low during READ -> bus_we stays 0, RAM 0x200 unchanged, no rsp_valid, req_ready 1 after release.
REQ-035 Back-to-back: req_valid held high with two loads -> second accepted in cycle after first rsp_valid, req_ready low in between.
